// File: rtl/parity_rx_pkg.sv
// Shared definitions for the 8-bit parity receive path.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : data bits per frame
//   parity8    : XOR-reduction of a data byte, shared with the downstream checker
package parity_rx_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // 1 when the byte holds an odd number of ones.
   function automatic logic parity8(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver: start / 8 data (LSB first) / parity / stop. Delivers the byte plus the raw
// parity bit over valid/ready and flags parity, framing and overrun errors.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_in       : serial line, idle high
//   data_out    : received byte
//   parity_out  : parity bit as received
//   parity_err  : received parity disagrees with PARITY_ODD
//   frame_err   : stop bit sampled low
//   out_valid   : outputs valid and held until out_ready
//   out_ready   : downstream accepts the current output
//   overrun     : sticky, a completed frame was dropped while the output was held
module parity_frame_rx
   import parity_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_ODD   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   logic rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 frame_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid-start-bit recheck rejects glitches shorter than half a bit.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == IDX_LAST) state_d = PARITY;
               else bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               frame_done = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed frame loads only if the output slot is free or being freed this cycle.
   logic load;
   assign load = frame_done && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         data_out   <= '0;
         parity_out <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         if (load) begin
            data_out   <= shift_q;
            parity_out <= par_q;
            parity_err <= (parity8(shift_q) ^ par_q) != PARITY_ODD;
            frame_err  <= !rx_s;
            out_valid  <= 1'b1;
         end else if (frame_done) begin
            overrun <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: odd- and even-parity instances share one line; a frame-level
// scoreboard predicts every output cycle, and directed scenarios pin literal values.
module tb_parity_frame_rx;

   localparam int C = 4;
   localparam int LAT = 3 + C / 2 + 10 * C;  // drive of start edge -> load edge

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_in = 1'b1;
   logic out_ready = 1'b0;

   logic [7:0] d_o, d_e;
   logic p_o, p_e, pe_o, pe_e, fe_o, fe_e, v_o, v_e, ov_o, ov_e;

   always #5 clk = ~clk;

   parity_frame_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(d_o), .parity_out(p_o),
      .parity_err(pe_o), .frame_err(fe_o), .out_valid(v_o), .out_ready(out_ready),
      .overrun(ov_o)
   );

   parity_frame_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(d_e), .parity_out(p_e),
      .parity_err(pe_e), .frame_err(fe_e), .out_valid(v_e), .out_ready(out_ready),
      .overrun(ov_e)
   );

   typedef struct {
      int         due;
      logic [7:0] data;
      logic       par;
      logic       stop;
   } frame_t;

   frame_t pend[$];
   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   bit rand_ready = 1'b0;

   logic       exp_v = 1'b0, exp_ov = 1'b0, exp_p = 1'b0, exp_f = 1'b0;
   logic       exp_pe_o = 1'b0, exp_pe_e = 1'b0;
   logic [7:0] exp_d = 8'h00;

   int deliv = 0;
   int valid_cycles = 0;
   logic [7:0] last_d;
   logic last_pe_o, last_pe_e, last_fe, last_p;

   function automatic logic ref_perr(input logic [7:0] d, input logic p, input bit odd);
      int ones;
      ones = int'(p);
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return odd ? (ones % 2 == 0) : (ones % 2 == 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: frames complete LAT edges after their start is driven; the output slot
   // follows the valid/ready rules.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            pend.delete();
            exp_v = 0; exp_ov = 0; exp_p = 0; exp_f = 0; exp_pe_o = 0; exp_pe_e = 0;
            exp_d = 0;
         end else begin
            if (v_o && out_ready) begin
               deliv++;
               last_d = d_o; last_p = p_o; last_pe_o = pe_o; last_pe_e = pe_e; last_fe = fe_o;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
               frame_t f;
               f = pend.pop_front();
               if (!exp_v || out_ready) begin
                  exp_v = 1; exp_d = f.data; exp_p = f.par; exp_f = !f.stop;
                  exp_pe_o = ref_perr(f.data, f.par, 1'b1);
                  exp_pe_e = ref_perr(f.data, f.par, 1'b0);
               end else begin
                  exp_ov = 1;
               end
            end else if (exp_v && out_ready) begin
               exp_v = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (v_o) valid_cycles++;
            chk("cycle_odd", {19'd0, v_o, ov_o, d_o, p_o, pe_o, fe_o},
                {19'd0, exp_v, exp_ov, exp_d, exp_p, exp_pe_o, exp_f});
            chk("cycle_even", {19'd0, v_e, ov_e, d_e, p_e, pe_e, fe_e},
                {19'd0, exp_v, exp_ov, exp_d, exp_p, exp_pe_e, exp_f});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      frame_t f;
      logic [10:0] bits;
      f.due = cyc + LAT; f.data = d; f.par = p; f.stop = s;
      pend.push_back(f);
      bits = {s, p, d, 1'b0};
      for (int k = 0; k < 11; k++) begin
         rx_in = bits[k];
         repeat (C) tick();
      end
      rx_in = 1'b1;
   endtask

   int base_d, base_v;

   initial begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs", {19'd0, v_o, ov_o, d_o, p_o, pe_o, fe_o, v_e, ov_e}, 32'd0);
      rst_n = 1'b1;

      // Idle line
      repeat (100) tick();
      chk("idle_quiet", {v_o, ov_o, d_o, v_e, ov_e}, 32'd0);

      // Good frame, odd parity
      out_ready = 1'b1;
      base_d = deliv; base_v = valid_cycles;
      send_frame(8'h55, 1'b1, 1'b1);
      repeat (4) tick();
      chk("good_count", deliv - base_d, 1);
      chk("good_valid_cycles", valid_cycles - base_v, 1);
      chk("good_data", last_d, 8'h55);
      chk("good_flags", {last_p, last_pe_o, last_fe}, 3'b100);

      // Bad parity and bad stop
      send_frame(8'hF0, 1'b0, 1'b0);
      repeat (2 * C + 4) tick();
      chk("bad_data", last_d, 8'hF0);
      chk("bad_flags", {last_pe_o, last_pe_e, last_fe}, 3'b101);

      // One-cycle glitch, then a frame soon after
      base_d = deliv;
      rx_in = 1'b0; tick();
      rx_in = 1'b1;
      repeat (C / 2 + 3) tick();
      chk("glitch_none", deliv - base_d, 0);
      send_frame(8'h96, 1'b1, 1'b1);
      repeat (4) tick();
      chk("after_glitch_count", deliv - base_d, 1);
      chk("after_glitch_data", last_d, 8'h96);

      // Backpressure: second back-to-back frame is dropped
      out_ready = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (4) tick();
      chk("ovr_held", {v_o, ov_o, d_o}, {2'b11, 8'hA5});
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      chk("ovr_after_accept", {v_o, ov_o}, 2'b01);
      repeat (3) tick();
      chk("ovr_sticky", ov_e, 1'b1);

      // Reset during data bit 3 of 0x81
      out_ready = 1'b1;
      begin
         logic [10:0] pb;
         pb = {1'b1, 1'b0, 8'h81, 1'b0};
         for (int k = 0; k < 4; k++) begin
            rx_in = pb[k];
            repeat (C) tick();
         end
         rx_in = pb[4];
         repeat (C / 2) tick();
      end
      rst_n = 1'b0;
      rx_in = 1'b1;
      repeat (2) tick();
      chk("midreset_clear", {v_o, ov_o, d_o, v_e, ov_e}, 32'd0);
      rst_n = 1'b1;
      repeat (4) tick();
      base_d = deliv;
      send_frame(8'h0F, 1'b1, 1'b1);
      repeat (4) tick();
      chk("midreset_count", deliv - base_d, 1);
      chk("midreset_data", last_d, 8'h0F);
      chk("midreset_perr", {last_pe_e, last_pe_o}, 2'b10);

      // Random frames with random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic p, s;
         d = 8'($urandom);
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 7) != 0);
         send_frame(d, p, s);
         repeat (s ? $urandom_range(0, 3) : 2 * C + $urandom_range(0, 3)) tick();
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      repeat (60) tick();
      chk("pending_drained", pend.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
